// File: rtl/elevator_plant_model.sv
// +-----------------------------------------------------------------------------+
// | elevator_plant_model: cycle-accurate car/shaft/door plant with interlocks.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module elevator_plant_model #(
  parameter int FLOORS       = 8,
  parameter int FLOOR_W      = 3,
  parameter int DELAY_ENGINE = 10,
  parameter int DELAY_DOOR   = 10,
  parameter int CNT_W        = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         engine_i,
  input  logic [1:0]         door_i,
  input  logic               obstruct_i,
  output logic [1:0]         sensor_door_o,
  output logic               sensor_up_o,
  output logic               sensor_down_o,
  output logic [FLOOR_W-1:0] floor_pos_o,
  output logic               at_floor_o,
  output logic               fault_o
);

  typedef enum logic [1:0] {M_IDLE, M_UP, M_DOWN} motion_e;
  typedef enum logic [1:0] {D_CLOSED, D_OPENING, D_OPEN, D_CLOSING} door_e;

  localparam logic [FLOOR_W-1:0] c_top       = FLOOR_W'(FLOORS - 1);
  localparam logic [CNT_W-1:0]   c_eng_load  = CNT_W'(DELAY_ENGINE - 1);
  localparam logic [CNT_W-1:0]   c_door_load = CNT_W'(DELAY_DOOR - 1);
  localparam logic [1:0]         c_sd_closed = 2'b10;
  localparam logic [1:0]         c_sd_open   = 2'b01;
  localparam logic [1:0]         c_sd_moving = 2'b00;

  motion_e            m_q, m_d;
  door_e              d_q, d_d;
  logic [CNT_W-1:0]   eng_cnt_q, eng_cnt_d, door_cnt_q, door_cnt_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               at_floor_q, at_floor_d, up_q, up_d, down_q, down_d;
  logic               fault_q, fault_d;
  logic [1:0]         sd_q, sd_d;

  logic w_cmd_up, w_cmd_dn, w_open_req, w_close_req;
  assign w_cmd_up    = (engine_i == 2'b01);
  assign w_cmd_dn    = (engine_i == 2'b10);
  assign w_open_req  = (door_i == 2'b01);
  assign w_close_req = (door_i == 2'b10);

  always_comb begin
    m_d        = m_q;
    d_d        = d_q;
    eng_cnt_d  = eng_cnt_q;
    door_cnt_d = door_cnt_q;
    floor_d    = floor_q;
    at_floor_d = at_floor_q;
    up_d       = up_q;
    down_d     = down_q;
    fault_d    = fault_q;
    sd_d       = sd_q;

    case (m_q)
      M_IDLE: begin
        // A door-open request in the same cycle takes precedence over motion.
        if (w_cmd_up || w_cmd_dn) begin
          if (d_q != D_CLOSED || w_open_req) begin
            fault_d = 1'b1;
          end else if ((w_cmd_up && floor_q == c_top) || (w_cmd_dn && floor_q == '0)) begin
            fault_d = 1'b1;
          end else begin
            m_d        = w_cmd_up ? M_UP : M_DOWN;
            eng_cnt_d  = c_eng_load;
            at_floor_d = 1'b0;
            up_d       = 1'b0;
            down_d     = 1'b0;
          end
        end
      end
      M_UP, M_DOWN: begin
        if (eng_cnt_q != '0) begin
          eng_cnt_d = eng_cnt_q - 1'b1;
        end else begin
          floor_d = (m_q == M_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          if ((m_q == M_UP && w_cmd_up && floor_d != c_top) ||
              (m_q == M_DOWN && w_cmd_dn && floor_d != '0)) begin
            eng_cnt_d = c_eng_load;
          end else begin
            m_d        = M_IDLE;
            at_floor_d = 1'b1;
            up_d       = (floor_d == c_top);
            down_d     = (floor_d == '0);
          end
        end
      end
      default: m_d = M_IDLE;
    endcase

    case (d_q)
      D_CLOSED: begin
        if (w_open_req) begin
          if (m_q == M_IDLE && at_floor_q) begin
            d_d        = D_OPENING;
            door_cnt_d = c_door_load;
            sd_d       = c_sd_moving;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      D_OPENING: begin
        if (door_cnt_q != '0) begin
          door_cnt_d = door_cnt_q - 1'b1;
        end else begin
          d_d  = D_OPEN;
          sd_d = c_sd_open;
        end
      end
      D_OPEN: begin
        if (w_close_req && !obstruct_i) begin
          d_d        = D_CLOSING;
          door_cnt_d = c_door_load;
          sd_d       = c_sd_moving;
        end
      end
      D_CLOSING: begin
        // Reopening retraces exactly the distance already closed.
        if (obstruct_i || w_open_req) begin
          d_d        = D_OPENING;
          door_cnt_d = c_door_load - door_cnt_q;
        end else if (door_cnt_q != '0) begin
          door_cnt_d = door_cnt_q - 1'b1;
        end else begin
          d_d  = D_CLOSED;
          sd_d = c_sd_closed;
        end
      end
      default: d_d = D_CLOSED;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_q        <= M_IDLE;
      d_q        <= D_CLOSED;
      eng_cnt_q  <= '0;
      door_cnt_q <= '0;
      floor_q    <= '0;
      at_floor_q <= 1'b1;
      up_q       <= 1'b0;
      down_q     <= 1'b1;
      fault_q    <= 1'b0;
      sd_q       <= c_sd_closed;
    end else begin
      m_q        <= m_d;
      d_q        <= d_d;
      eng_cnt_q  <= eng_cnt_d;
      door_cnt_q <= door_cnt_d;
      floor_q    <= floor_d;
      at_floor_q <= at_floor_d;
      up_q       <= up_d;
      down_q     <= down_d;
      fault_q    <= fault_d;
      sd_q       <= sd_d;
    end
  end

  assign sensor_door_o = sd_q;
  assign sensor_up_o   = up_q;
  assign sensor_down_o = down_q;
  assign floor_pos_o   = floor_q;
  assign at_floor_o    = at_floor_q;
  assign fault_o       = fault_q;

endmodule

`default_nettype wire
